// File: rtl/dds_pkg.sv
// Shared encodings and defaults for the DDS front-panel controller and
// the waveform generator it drives.
package dds_pkg;

   // Edit field selected by the Mode button; the value is exported as oEditSel
   typedef enum logic [1:0] {
      S_WAVE = 2'd0,
      S_FREQ = 2'd1,
      S_AMP  = 2'd2
   } state_t;

   // Waveform codes understood by the waveform generator
   typedef enum logic [1:0] {
      W_SINE     = 2'd0,
      W_SQUARE   = 2'd1,
      W_TRIANGLE = 2'd2,
      W_SAW      = 2'd3
   } wave_t;

   localparam logic [31:0] FREQ_DEF_C  = 32'd42950;
   localparam logic [31:0] FREQ_STEP_C = 32'd4295;
   localparam logic [31:0] FREQ_MAX_C  = 32'd2147483648;
   localparam logic [2:0]  AMP_MAX_C   = 3'd7;

endpackage

// File: rtl/dds_param_ctrl_if.sv
// Button inputs and parameter outputs of the DDS controller.
interface dds_param_ctrl_if;

   logic        iBtnMode;
   logic        iBtnUp;
   logic        iBtnDown;
   logic [1:0]  oEditSel;
   logic [1:0]  oWaveSel;
   logic [31:0] oFreqWord;
   logic [2:0]  oAmpSel;
   logic        oParamUpd;

   // Front panel / host side
   modport master (
      output iBtnMode, iBtnUp, iBtnDown,
      input  oEditSel, oWaveSel, oFreqWord, oAmpSel, oParamUpd
   );

   // Controller side
   modport slave (
      input  iBtnMode, iBtnUp, iBtnDown,
      output oEditSel, oWaveSel, oFreqWord, oAmpSel, oParamUpd
   );

endinterface

// File: rtl/dds_param_ctrl_sat_addsub.sv
// Saturating add/subtract of a fixed step, clamped to [lo, hi].
// A one-bit-wider intermediate keeps carries and borrows from wrapping.
module sat_addsub #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] val,
   input  logic [W-1:0] step,
   input  logic [W-1:0] lo,
   input  logic [W-1:0] hi,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] res
);

   logic [W:0] sum;
   logic [W:0] diff;

   // Compute next value; holds val when neither or both directions requested
   always_comb begin
      sum  = {1'b0, val} + {1'b0, step};
      diff = {1'b0, val} - {1'b0, step};
      res  = val;
      if (inc && !dec) begin
         res = (sum > {1'b0, hi}) ? hi : sum[W-1:0];
      end else if (dec && !inc) begin
         res = (diff[W] || (diff[W-1:0] < lo)) ? lo : diff[W-1:0];
      end
   end

endmodule

// File: rtl/dds_param_ctrl.sv
// DDS parameter editor: Mode cycles the edit field, Up/Down adjust the
// selected waveform, tuning word or amplitude, and a one-cycle strobe
// flags any real change.
module dds_param_ctrl
   import dds_pkg::*;
#(
   parameter logic [31:0] FREQ_DEF  = FREQ_DEF_C,
   parameter logic [31:0] FREQ_STEP = FREQ_STEP_C,
   parameter logic [31:0] FREQ_MAX  = FREQ_MAX_C,
   parameter logic [2:0]  AMP_MAX   = AMP_MAX_C
) (
   input  logic                CLK,
   input  logic                RESETn,
   dds_param_ctrl_if.slave     bus
);

   state_t      state_q, state_d;
   wave_t       wave_q, wave_d;
   logic [31:0] freq_q, freq_d, freq_sat;
   logic [2:0]  amp_q, amp_d, amp_sat;
   logic        upd_q, upd_d;
   logic        adj_up, adj_dn;

   // Mode overrides adjustment, and Up+Down together cancel out
   assign adj_up = bus.iBtnUp   & ~bus.iBtnDown & ~bus.iBtnMode;
   assign adj_dn = bus.iBtnDown & ~bus.iBtnUp   & ~bus.iBtnMode;

   sat_addsub #(.W(32)) u_freq_sat (
      .val  (freq_q),
      .step (FREQ_STEP),
      .lo   (FREQ_STEP),
      .hi   (FREQ_MAX),
      .inc  (adj_up && (state_q == S_FREQ)),
      .dec  (adj_dn && (state_q == S_FREQ)),
      .res  (freq_sat)
   );

   sat_addsub #(.W(3)) u_amp_sat (
      .val  (amp_q),
      .step (3'd1),
      .lo   (3'd0),
      .hi   (AMP_MAX),
      .inc  (adj_up && (state_q == S_AMP)),
      .dec  (adj_dn && (state_q == S_AMP)),
      .res  (amp_sat)
   );

   // State and parameter registers with asynchronous reset
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= S_WAVE;
         wave_q  <= W_SINE;
         freq_q  <= FREQ_DEF;
         amp_q   <= AMP_MAX;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wave_q  <= wave_d;
         freq_q  <= freq_d;
         amp_q   <= amp_d;
         upd_q   <= upd_d;
      end
   end

   // Next field selection and next value of the field being edited
   always_comb begin
      state_d = state_q;
      wave_d  = wave_q;
      freq_d  = freq_q;
      amp_d   = amp_q;
      case (state_q)
         S_WAVE: begin
            if (bus.iBtnMode)  state_d = S_FREQ;
            else if (adj_up)   wave_d  = wave_t'(wave_q + 2'd1);
            else if (adj_dn)   wave_d  = wave_t'(wave_q - 2'd1);
         end
         S_FREQ: begin
            if (bus.iBtnMode)  state_d = S_AMP;
            else               freq_d  = freq_sat;
         end
         S_AMP: begin
            if (bus.iBtnMode)  state_d = S_WAVE;
            else               amp_d   = amp_sat;
         end
         default: state_d = S_WAVE;
      endcase
      upd_d = (wave_d != wave_q) || (freq_d != freq_q) || (amp_d != amp_q);
   end

   assign bus.oEditSel  = state_q;
   assign bus.oWaveSel  = wave_q;
   assign bus.oFreqWord = freq_q;
   assign bus.oAmpSel   = amp_q;
   assign bus.oParamUpd = upd_q;

endmodule

// File: tb/tb_dds_param_ctrl.sv
// Directed bench for dds_param_ctrl with an arithmetic reference model
// compared against the outputs every cycle.
module tb_dds_param_ctrl;

   localparam longint F_DEF  = 42950;
   localparam longint F_STEP = 4295;
   localparam longint F_MAX  = 64'd2147483648;
   localparam int     A_MAX  = 7;

   logic CLK;
   logic RESETn;
   dds_param_ctrl_if bus ();

   dds_param_ctrl #(
      .FREQ_DEF  (32'd42950),
      .FREQ_STEP (32'd4295),
      .FREQ_MAX  (32'd2147483648),
      .AMP_MAX   (3'd7)
   ) dut (
      .CLK    (CLK),
      .RESETn (RESETn),
      .bus    (bus)
   );

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 0;

   // Reference model state
   int     m_edit, m_wave, m_amp;
   longint m_freq;
   bit     m_upd;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Model: apply the button rules to the panel values on each edge
   always @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         m_edit = 0; m_wave = 0; m_freq = F_DEF; m_amp = A_MAX; m_upd = 0;
      end else begin
         int     o_wave, o_amp, dir;
         longint o_freq, nf;
         o_wave = m_wave; o_amp = m_amp; o_freq = m_freq;
         if (bus.iBtnMode) begin
            m_edit = (m_edit + 1) % 3;
         end else if (bus.iBtnUp != bus.iBtnDown) begin
            dir = bus.iBtnUp ? 1 : -1;
            if (m_edit == 0) m_wave = (m_wave + dir + 4) % 4;
            else if (m_edit == 1) begin
               nf = m_freq + dir * F_STEP;
               if (nf > F_MAX)  nf = F_MAX;
               if (nf < F_STEP) nf = F_STEP;
               m_freq = nf;
            end else begin
               m_amp = m_amp + dir;
               if (m_amp > A_MAX) m_amp = A_MAX;
               if (m_amp < 0)     m_amp = 0;
            end
         end
         m_upd = (o_wave != m_wave) || (o_amp != m_amp) || (o_freq != m_freq);
      end
   end

   // Compare all outputs against the model mid-cycle
   always @(negedge CLK) begin
      if (chk_en) begin
         check("edit",  bus.oEditSel,  m_edit);
         check("wave",  bus.oWaveSel,  m_wave);
         check("freq",  bus.oFreqWord, m_freq);
         check("amp",   bus.oAmpSel,   m_amp);
         check("upd",   bus.oParamUpd, m_upd);
      end
   end

   // One-cycle button pulse; returns just after the capturing edge
   task automatic cyc(input bit m, input bit u, input bit d);
      @(negedge CLK);
      bus.iBtnMode = m; bus.iBtnUp = u; bus.iBtnDown = d;
      @(posedge CLK);
      #1;
      bus.iBtnMode = 0; bus.iBtnUp = 0; bus.iBtnDown = 0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_freq"}, bus.oFreqWord, 42950);
      check({tag, "_amp"},  bus.oAmpSel,   7);
      check({tag, "_wave"}, bus.oWaveSel,  0);
      check({tag, "_edit"}, bus.oEditSel,  0);
      check({tag, "_upd"},  bus.oParamUpd, 0);
   endtask

   initial begin
      int     strobes;
      int     wexp[4];
      longint fexp;
      wexp = '{1, 2, 3, 0};
      RESETn = 1'b0;
      bus.iBtnMode = 0; bus.iBtnUp = 0; bus.iBtnDown = 0;
      repeat (3) @(negedge CLK);
      RESETn = 1'b1;
      @(posedge CLK); #1;
      check_reset_vals("rst");
      chk_en = 1;

      // Waveform wrap upward, then downward
      strobes = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 0);
         check("wave_up", bus.oWaveSel, wexp[i]);
         if (bus.oParamUpd) strobes++;
      end
      check("wave_strobes", strobes, 4);
      cyc(0, 0, 1);
      check("wave_dn_wrap", bus.oWaveSel, 3);

      // Frequency down to the floor
      cyc(1, 0, 0);
      check("mode_freq", bus.oEditSel, 1);
      check("mode_noupd", bus.oParamUpd, 0);
      strobes = 0;
      for (int k = 1; k <= 10; k++) begin
         cyc(0, 0, 1);
         fexp = (k < 10) ? (42950 - 4295 * k) : 4295;
         check("freq_dn", bus.oFreqWord, fexp);
         if (bus.oParamUpd) strobes++;
      end
      check("freq_strobes", strobes, 9);
      check("freq_floor_noupd", bus.oParamUpd, 0);

      // Up and Down together cancel
      cyc(0, 1, 1);
      check("updn_freq", bus.oFreqWord, 4295);
      check("updn_noupd", bus.oParamUpd, 0);

      // Up held high for three cycles counts three presses
      @(negedge CLK);
      bus.iBtnUp = 1;
      for (int i = 1; i <= 3; i++) begin
         @(posedge CLK); #1;
         check("held_up", bus.oFreqWord, 4295 + 4295 * i);
         check("held_upd", bus.oParamUpd, 1);
      end
      bus.iBtnUp = 0;

      // Mode beats Up
      cyc(1, 1, 0);
      check("modeup_edit", bus.oEditSel, 2);
      check("modeup_freq", bus.oFreqWord, 17180);
      check("modeup_noupd", bus.oParamUpd, 0);

      // Amplitude ceiling and floor
      cyc(0, 1, 0);
      check("amp_ceil", bus.oAmpSel, 7);
      check("amp_ceil_noupd", bus.oParamUpd, 0);
      for (int i = 6; i >= -1; i--) begin
         cyc(0, 0, 1);
         check("amp_dn", bus.oAmpSel, (i < 0) ? 0 : i);
         check("amp_dn_upd", bus.oParamUpd, (i < 0) ? 0 : 1);
      end

      // Back to waveform, change it, then reset during the strobe
      cyc(1, 0, 0);
      check("mode_wrap", bus.oEditSel, 0);
      cyc(0, 1, 0);
      check("pre_rst_wave", bus.oWaveSel, 0);
      check("pre_rst_upd", bus.oParamUpd, 1);
      #2 RESETn = 1'b0;
      #1;
      check_reset_vals("midrst");
      @(negedge CLK);
      RESETn = 1'b1;

      // First press after reset is honoured
      cyc(0, 1, 0);
      check("post_rst_wave", bus.oWaveSel, 1);
      check("post_rst_upd", bus.oParamUpd, 1);
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      check("post_rst_wrap", bus.oWaveSel, 3);

      @(negedge CLK);
      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dds_param_ctrl.md
DDS_PARAM_CTRL -- requirements
Module: dds_param_ctrl

Interface
REQ-001 Parameter FREQ_DEF, 32'd42950, reset frequency tuning word.
REQ-002 Parameter FREQ_STEP, 32'd4295, tuning-word increment per Up/Down press.
REQ-003 Parameter FREQ_MAX, 32'd2147483648, maximum tuning word (Nyquist).
REQ-004 Parameter AMP_MAX, 3'd7, maximum amplitude code.
REQ-005 CLK  input  1  system clock; all logic on rising edge.
REQ-006 RESETn  input  1  reset, asynchronous, active-low.
REQ-007 iBtnMode  input  1  single-cycle pulse from the debounced Mode button; selects the next edit field.
REQ-008 iBtnUp  input  1  single-cycle pulse from the debounced Up button.
REQ-009 iBtnDown  input  1  single-cycle pulse from the debounced Down button.
REQ-010 oEditSel  output  2  current edit field: 0 WAVE, 1 FREQ, 2 AMP.
REQ-011 oWaveSel  output  2  waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-012 oFreqWord  output  32  DDS phase-accumulator increment.
REQ-013 oAmpSel  output  3  amplitude attenuation code; 7 is full scale.
REQ-014 oParamUpd  output  1  one-cycle strobe; a parameter changed on the previous edge.

Function
REQ-015 FSM states: S_WAVE, S_FREQ, S_AMP; oEditSel is the registered state code.
REQ-016 iBtnMode moves S_WAVE->S_FREQ->S_AMP->S_WAVE on the same edge; parameters are unchanged.
REQ-017 Up/Down pulses act on the field of the current state only.
REQ-018 In S_WAVE, Up does oWaveSel+1 and Down does oWaveSel-1, modulo 4 (3->0 and 0->3 wrap).
REQ-019 In S_FREQ, Up does oFreqWord+FREQ_STEP, saturating at FREQ_MAX; Down does oFreqWord-FREQ_STEP, saturating at FREQ_STEP (never 0).
REQ-020 Frequency arithmetic uses a 33-bit intermediate; overflow or underflow never wraps.
REQ-021 In S_AMP, Up/Down do +1/-1, saturating at AMP_MAX and 0.
REQ-022 Parameter outputs are registered; a pulse sampled high at edge N updates the output at edge N (visible after edge N).
REQ-023 oParamUpd is 1 for exactly the cycle after edge N, and only if a parameter value actually changed.
REQ-024 Saturation or a state change with no value change gives no strobe.
REQ-025 Simultaneous iBtnUp and iBtnDown: both are ignored, with no change and no strobe.
REQ-026 iBtnMode together with Up or Down: Mode wins and the adjustment is dropped.
REQ-027 Inputs held high for several cycles are treated as one press per cycle; no internal edge detection, since the upstream stage guarantees pulses.

Reset
REQ-028 RESETn low asynchronously forces: state S_WAVE, oWaveSel 0, oFreqWord FREQ_DEF, oAmpSel AMP_MAX, oParamUpd 0.
REQ-029 Reset asserted mid-operation discards any pending strobe.
REQ-030 The first press after RESETn deasserts is processed normally.

Structure
REQ-031 Package dds_pkg holds the state encodings, waveform encodings, and default and step constants shared with the waveform generator.
REQ-032 Sub-module sat_addsub (a saturating add/subtract with min and max bounds) serves both the frequency field and the amplitude field.
REQ-033 The target implementation is 120-400 lines; no memories and no multipliers.

Verification
REQ-034 Reset, then idle: oFreqWord=42950, oAmpSel=7, oWaveSel=0, oEditSel=0, oParamUpd=0.
REQ-035 In S_WAVE, 4 Up pulses -> oWaveSel 1,2,3,0, with 4 strobes; then 1 Down -> 3.
REQ-036 One Mode pulse then 10 Down pulses -> oFreqWord 38655 ... 4295, then held at 4295; strobes only on actual changes (9), none on the 10th.
REQ-037 Mode x2 to S_AMP, then Up -> oAmpSel stays 7 with no strobe; Down -> 6 with one strobe.
REQ-038 In S_FREQ, Up and Down in the same cycle -> no change, no strobe; Mode+Up together -> oEditSel=2, oFreqWord unchanged.
REQ-039 RESETn pulsed low mid-sequence, one cycle after a change -> oParamUpd=0 and all outputs at reset values immediately.
